// File: rtl/bhr_checkpoint_pkg.sv
// Shared widths and types for the BHR checkpoint slice.
// BHR_ARCH_RECOVER_EN (optional) enables flush recovery from the architectural history.
`ifndef BRANCH_HISTORY_REG_SZ
`define BRANCH_HISTORY_REG_SZ 4
`endif

package bhr_checkpoint_pkg;
   localparam int BHR_DEPTH  = `BRANCH_HISTORY_REG_SZ;
   localparam int CKPT_DEPTH = 8;
   localparam int TAG_W      = $clog2(CKPT_DEPTH);

   typedef logic [BHR_DEPTH-1:0] BHR_T;
   typedef logic [TAG_W-1:0]     BR_TAG;
endpackage

// File: rtl/bhr_checkpoint_if.sv
// Fetch-side predict/resolve/retire bundle between the front end and bhr_checkpoint.
// BHR_ARCH_RECOVER_EN adds the flush request.
interface bhr_checkpoint_if #(
   parameter int BHR_DEPTH  = bhr_checkpoint_pkg::BHR_DEPTH,
   parameter int CKPT_DEPTH = bhr_checkpoint_pkg::CKPT_DEPTH
);
   localparam int TAG_W = $clog2(CKPT_DEPTH);

   logic                 pred_valid;
   logic                 pred_taken;
   logic                 pred_ready;
   logic [TAG_W-1:0]     pred_tag;
   logic [BHR_DEPTH-1:0] cur_bhr;
   logic                 res_valid;
   logic [TAG_W-1:0]     res_tag;
   logic                 res_taken;
   logic                 res_mispredict;
   logic [BHR_DEPTH-1:0] res_bhr;
   logic                 retire_valid;
   logic [TAG_W:0]       count;
`ifdef BHR_ARCH_RECOVER_EN
   logic                 flush;
`endif

   modport master (
`ifdef BHR_ARCH_RECOVER_EN
      output flush,
`endif
      output pred_valid, pred_taken, res_valid, res_tag, res_taken, res_mispredict, retire_valid,
      input  pred_ready, pred_tag, cur_bhr, res_bhr, count
   );

   modport slave (
`ifdef BHR_ARCH_RECOVER_EN
      input  flush,
`endif
      input  pred_valid, pred_taken, res_valid, res_tag, res_taken, res_mispredict, retire_valid,
      output pred_ready, pred_tag, cur_bhr, res_bhr, count
   );
endinterface

// File: rtl/bhr_ckpt_buf.sv
// Circular checkpoint buffer: head/tail/count bookkeeping, one write port, one async read port.
module bhr_ckpt_buf #(
   parameter int  DATA_W = 4,
   parameter int  DEPTH  = 8,
   localparam int TAG_W  = $clog2(DEPTH)
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              clear,
   input  logic              push,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop,
   input  logic              rewind,
   input  logic [TAG_W-1:0]  rewind_tag,
   input  logic [TAG_W-1:0]  rd_tag,
   output logic [DATA_W-1:0] rd_data,
   output logic [TAG_W-1:0]  head,
   output logic [TAG_W-1:0]  tail,
   output logic [TAG_W:0]    count
);
   localparam logic [TAG_W-1:0] TAG_ONE = TAG_W'(1);
   localparam logic [TAG_W:0]   CNT_ONE = (TAG_W+1)'(1);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [TAG_W-1:0]  head_reg, head_next, tail_reg, tail_next, rewind_off;
   logic [TAG_W:0]    count_reg, count_next;

   always_comb begin
      head_next  = head_reg;
      tail_next  = tail_reg;
      count_next = count_reg;
      rewind_off = rewind_tag - head_reg;
      if (clear) begin
         head_next  = '0;
         tail_next  = '0;
         count_next = '0;
      end else begin
         if (pop)
            head_next = head_reg + TAG_ONE;
         // A rewind keeps everything from head up to and including the resolved slot.
         if (rewind) begin
            tail_next  = rewind_tag + TAG_ONE;
            count_next = {1'b0, rewind_off} + CNT_ONE - {{TAG_W{1'b0}}, pop};
         end else begin
            if (push)
               tail_next = tail_reg + TAG_ONE;
            count_next = count_reg + {{TAG_W{1'b0}}, push} - {{TAG_W{1'b0}}, pop};
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         head_reg  <= '0;
         tail_reg  <= '0;
         count_reg <= '0;
      end else begin
         head_reg  <= head_next;
         tail_reg  <= tail_next;
         count_reg <= count_next;
      end
   end

   always_ff @(posedge clock) begin
      if (push)
         mem[tail_reg] <= push_data;
   end

   assign rd_data = mem[rd_tag];
   assign head    = head_reg;
   assign tail    = tail_reg;
   assign count   = count_reg;
endmodule

// File: rtl/bhr_checkpoint.sv
// Speculative BHR with per-branch pre-shift checkpoints and mispredict recovery.
// Define BHR_ARCH_RECOVER_EN to add flush recovery from a retired-history register.
module bhr_checkpoint #(
   parameter int BHR_DEPTH  = bhr_checkpoint_pkg::BHR_DEPTH,
   parameter int CKPT_DEPTH = bhr_checkpoint_pkg::CKPT_DEPTH
) (
   input  logic             clock,
   input  logic             reset,
   bhr_checkpoint_if.slave  bus
);
   import bhr_checkpoint_pkg::*;

   localparam int             TAG_W      = $clog2(CKPT_DEPTH);
   localparam logic [TAG_W:0] FULL_COUNT = (TAG_W+1)'(CKPT_DEPTH);

   logic [BHR_DEPTH-1:0] spec_bhr_reg, spec_bhr_next, ckpt_rd;
   logic [TAG_W-1:0]     head, tail;
   logic [TAG_W:0]       count;
   logic                 mispredict, accept, retire, flush;

   assign mispredict = bus.res_valid && bus.res_mispredict;
   assign retire     = bus.retire_valid && (count != '0) && !flush;
   // A same-cycle retire frees the head slot, so a predict is taken even when full.
   assign accept     = bus.pred_valid && ((count != FULL_COUNT) || retire) && !mispredict && !flush;

   bhr_ckpt_buf #(
      .DATA_W (BHR_DEPTH),
      .DEPTH  (CKPT_DEPTH)
   ) u_buf (
      .clock      (clock),
      .reset      (reset),
      .clear      (flush),
      .push       (accept),
      .push_data  (spec_bhr_reg),
      .pop        (retire),
      .rewind     (mispredict),
      .rewind_tag (bus.res_tag),
      .rd_tag     (bus.res_tag),
      .rd_data    (ckpt_rd),
      .head       (head),
      .tail       (tail),
      .count      (count)
   );

`ifdef BHR_ARCH_RECOVER_EN
   logic [CKPT_DEPTH-1:0] dir_reg;
   logic [BHR_DEPTH-1:0]  arch_bhr_reg;
   logic                  retired_dir;

   assign flush       = bus.flush;
   // A branch mispredicted and retired in the same cycle retires with its corrected direction.
   assign retired_dir = (mispredict && (bus.res_tag == head)) ? bus.res_taken : dir_reg[head];

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         dir_reg      <= '0;
         arch_bhr_reg <= '0;
      end else begin
         if (accept)
            dir_reg[tail] <= bus.pred_taken;
         if (mispredict && !flush)
            dir_reg[bus.res_tag] <= bus.res_taken;
         if (retire)
            arch_bhr_reg <= {arch_bhr_reg[BHR_DEPTH-2:0], retired_dir};
      end
   end
`else
   assign flush = 1'b0;
`endif

   always_comb begin
      spec_bhr_next = spec_bhr_reg;
      if (mispredict)
         spec_bhr_next = {ckpt_rd[BHR_DEPTH-2:0], bus.res_taken};
      else if (accept)
         spec_bhr_next = {spec_bhr_reg[BHR_DEPTH-2:0], bus.pred_taken};
`ifdef BHR_ARCH_RECOVER_EN
      if (flush)
         spec_bhr_next = arch_bhr_reg;
`endif
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         spec_bhr_reg <= '0;
      else
         spec_bhr_reg <= spec_bhr_next;
   end

   assign bus.pred_ready = (count != FULL_COUNT);
   assign bus.pred_tag   = tail;
   assign bus.cur_bhr    = spec_bhr_reg;
   assign bus.res_bhr    = ckpt_rd;
   assign bus.count      = count;

`ifndef SYNTHESIS
   logic [TAG_W-1:0] res_off;
   assign res_off = bus.res_tag - head;

   retire_nonempty: assert property (@(posedge clock) disable iff (!reset)
      bus.retire_valid |-> (count != '0));
   res_tag_inflight: assert property (@(posedge clock) disable iff (!reset)
      bus.res_valid |-> ({1'b0, res_off} < count));
`endif
endmodule

// File: tb/tb_bhr_checkpoint.sv
// Randomized bench for bhr_checkpoint against an in-order queue model of in-flight branches.
module tb_bhr_checkpoint;
   localparam int D = 4;

   logic clock;
   logic reset;
   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;
   bit   model_on = 0;

   // Model: in-flight checkpoints oldest-first; tag of entry i is (m_head + i) mod D.
   logic [3:0] mq[$];
   int         m_head = 0;
   logic [3:0] m_spec = '0;

   bhr_checkpoint_if #(.BHR_DEPTH(4), .CKPT_DEPTH(D)) bus ();

   bhr_checkpoint #(.BHR_DEPTH(4), .CKPT_DEPTH(D)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_head = 0;
      m_spec = '0;
   endtask

   task automatic model_step();
      int         idx;
      bit         acc;
      logic [3:0] base;
      if (bus.res_valid && bus.res_mispredict) begin
         idx  = (int'(bus.res_tag) - m_head + D) % D;
         base = mq[idx];
         while (mq.size() > idx + 1) void'(mq.pop_back());
         m_spec = {base[2:0], bus.res_taken};
         if (bus.retire_valid) begin
            void'(mq.pop_front());
            m_head = (m_head + 1) % D;
         end
      end else begin
         acc = bus.pred_valid && ((mq.size() < D) || (bus.retire_valid && mq.size() > 0));
         if (bus.retire_valid && mq.size() > 0) begin
            void'(mq.pop_front());
            m_head = (m_head + 1) % D;
         end
         if (acc) begin
            mq.push_back(m_spec);
            m_spec = {m_spec[2:0], bus.pred_taken};
         end
      end
   endtask

   // Compare process: DUT outputs against the model on every live cycle.
   always @(negedge clock) begin
      int idx;
      if (reset && model_on) begin
         chk("pred_ready", 32'(bus.pred_ready), 32'(mq.size() != D));
         chk("pred_tag", 32'(bus.pred_tag), 32'((m_head + mq.size()) % D));
         chk("cur_bhr", 32'(bus.cur_bhr), 32'(m_spec));
         chk("count", 32'(bus.count), 32'(mq.size()));
         if (bus.res_valid) begin
            idx = (int'(bus.res_tag) - m_head + D) % D;
            chk("res_bhr", 32'(bus.res_bhr), 32'(mq[idx]));
         end
      end
   end

   task automatic drive(input bit pv, input bit pt, input bit rv, input int rtag,
                        input bit rtak, input bit rmis, input bit ret);
      bus.pred_valid     = pv;
      bus.pred_taken     = pt;
      bus.res_valid      = rv;
      bus.res_tag        = 2'(rtag);
      bus.res_taken      = rtak;
      bus.res_mispredict = rmis;
      bus.retire_valid   = ret;
   endtask

   task automatic tick();
      @(posedge clock);
      if (model_on) model_step();
      #1;
      cyc++;
      $display("cyc %0d pv=%0b pt=%0b rv=%0b tag=%0d tk=%0b mis=%0b ret=%0b -> cur_bhr=%b count=%0d tag=%0d",
               cyc, bus.pred_valid, bus.pred_taken, bus.res_valid, bus.res_tag, bus.res_taken,
               bus.res_mispredict, bus.retire_valid, bus.cur_bhr, bus.count, bus.pred_tag);
      drive(0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      int sz;
      bit pv, pt, rv, rtak, rmis, ret;
      int rtag;
      reset = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0);
`ifdef BHR_ARCH_RECOVER_EN
      bus.flush = 1'b0;
`endif
      @(posedge clock);
      #2 reset = 1'b1;
      model_on = 1;
      chk("rst_ready", 32'(bus.pred_ready), 32'd1);
      chk("rst_tag", 32'(bus.pred_tag), 32'd0);
      chk("rst_bhr", 32'(bus.cur_bhr), 32'd0);
      chk("rst_count", 32'(bus.count), 32'd0);

      // Predicts T, N, T.
      chk("s1_tag0", 32'(bus.pred_tag), 32'd0);
      drive(1, 1, 0, 0, 0, 0, 0); tick();
      chk("s1_bhr0", 32'(bus.cur_bhr), 32'b0001);
      chk("s1_tag1", 32'(bus.pred_tag), 32'd1);
      drive(1, 0, 0, 0, 0, 0, 0); tick();
      chk("s1_bhr1", 32'(bus.cur_bhr), 32'b0010);
      chk("s1_tag2", 32'(bus.pred_tag), 32'd2);
      drive(1, 1, 0, 0, 0, 0, 0); tick();
      chk("s1_bhr2", 32'(bus.cur_bhr), 32'b0101);
      chk("s1_count", 32'(bus.count), 32'd3);
      chk("model_s1", 32'(m_spec), 32'b0101);

      // Mispredict tag 1 taken.
      drive(0, 0, 1, 1, 1, 1, 0);
      #1 chk("s3_res_bhr", 32'(bus.res_bhr), 32'b0001);
      tick();
      chk("s3_bhr", 32'(bus.cur_bhr), 32'b0011);
      chk("s3_tail", 32'(bus.pred_tag), 32'd2);
      chk("s3_count", 32'(bus.count), 32'd2);

      // Predict dropped by a head mispredict with simultaneous retire.
      drive(1, 1, 1, 0, 1, 1, 1); tick();
      chk("s4_count", 32'(bus.count), 32'd0);
      chk("s4_tail", 32'(bus.pred_tag), 32'd1);
      chk("s4_bhr", 32'(bus.cur_bhr), 32'b0001);

      // Fill, over-issue, then retire+predict while full.
      drive(1, 1, 0, 0, 0, 0, 0); tick();
      drive(1, 1, 0, 0, 0, 0, 0); tick();
      drive(1, 0, 0, 0, 0, 0, 0); tick();
      drive(1, 1, 0, 0, 0, 0, 0); tick();
      chk("s2_full_ready", 32'(bus.pred_ready), 32'd0);
      chk("s2_full_count", 32'(bus.count), 32'd4);
      chk("s2_full_bhr", 32'(bus.cur_bhr), 32'b1101);
      drive(1, 0, 0, 0, 0, 0, 0); tick();
      chk("s2_ign_bhr", 32'(bus.cur_bhr), 32'b1101);
      chk("s2_ign_tail", 32'(bus.pred_tag), 32'd1);
      drive(1, 0, 0, 0, 0, 0, 1); tick();
      chk("s2_rp_count", 32'(bus.count), 32'd4);
      chk("s2_rp_tail", 32'(bus.pred_tag), 32'd2);
      chk("s2_rp_bhr", 32'(bus.cur_bhr), 32'b1010);
      chk("model_s2", 32'(m_head), 32'd2);

      // Asynchronous reset with three in flight.
      drive(0, 0, 0, 0, 0, 0, 1); tick();
      chk("s5_pre_count", 32'(bus.count), 32'd3);
      reset = 1'b0;
      #1;
      chk("s5_count", 32'(bus.count), 32'd0);
      chk("s5_bhr", 32'(bus.cur_bhr), 32'd0);
      chk("s5_ready", 32'(bus.pred_ready), 32'd1);
      model_reset();
      @(posedge clock);
      #2 reset = 1'b1;

      // Randomized legal traffic.
      for (int n = 0; n < 1500; n++) begin
         sz   = mq.size();
         pv   = ($urandom_range(0, 99) < 65);
         pt   = 1'($urandom_range(0, 1));
         ret  = (sz > 0) && ($urandom_range(0, 99) < 30);
         rv   = (sz > 0) && ($urandom_range(0, 99) < 40);
         rtag = (sz > 0) ? (m_head + int'($urandom_range(0, sz - 1))) % D : 0;
         rtak = 1'($urandom_range(0, 1));
         rmis = rv && ($urandom_range(0, 99) < 25);
         drive(pv, pt, rv, rtag, rtak, rmis, ret);
         tick();
      end

`ifdef BHR_ARCH_RECOVER_EN
      model_on = 0;
      reset = 1'b0;
      @(posedge clock);
      #2 reset = 1'b1;
      drive(1, 1, 0, 0, 0, 0, 0); tick();
      drive(1, 1, 0, 0, 0, 0, 0); tick();
      drive(0, 0, 0, 0, 0, 0, 1); tick();
      drive(0, 0, 0, 0, 0, 0, 1); tick();
      drive(1, 0, 0, 0, 0, 0, 0); tick();
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
      chk("flush_bhr", 32'(bus.cur_bhr), 32'b0011);
      chk("flush_count", 32'(bus.count), 32'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/bhr_checkpoint.md
Name: bhr_checkpoint

Overview:
- Owns the speculative branch history register (BHR) that drives the predictor's read-side history input.
- Checkpoints the pre-shift history of every in-flight conditional branch in a circular buffer.
- Supplies the per-branch history the predictor's write port needs at resolve time.
- Restores history on misprediction. Sits in fetch, directly upstream of the predictor.

Parameters:
- BHR_DEPTH, `BRANCH_HISTORY_REG_SZ, history bits; must match the predictor.
- CKPT_DEPTH, 8, max in-flight predicted branches; power of 2, at least 2.
- TAG_W, $clog2(CKPT_DEPTH), branch tag width (localparam).

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- pred_valid  in  1  a conditional branch was predicted this cycle
- pred_taken  in  1  predicted direction of that branch
- pred_ready  out  1  checkpoint slot free; pred_valid is accepted only when high
- pred_tag  out  TAG_W  tag allocated to the accepted branch (= tail)
- cur_bhr  out  BHR_DEPTH  speculative history; wired to predictor rd_bhr
- res_valid  in  1  a branch resolved this cycle
- res_tag  in  TAG_W  tag of the resolved branch
- res_taken  in  1  actual direction
- res_mispredict  in  1  direction was mispredicted
- res_bhr  out  BHR_DEPTH  checkpoint[res_tag], combinational; wired to predictor wr_bhr
- retire_valid  in  1  oldest branch committed; frees the head slot
- count  out  TAG_W+1  occupied slots

Behaviour:
- State:
  - spec_bhr register.
  - ckpt array of CKPT_DEPTH x BHR_DEPTH.
  - head, tail (TAG_W, wrap mod CKPT_DEPTH).
  - count (TAG_W+1).
- Reset (reset==0, async):
  - spec_bhr=0, head=tail=0, count=0.
  - Outputs: pred_ready=1, pred_tag=0, cur_bhr=0.
  - ckpt contents are don't-care.
  - Reset mid-operation discards all in-flight checkpoints.
- pred_ready = (count != CKPT_DEPTH). pred_tag = tail. cur_bhr = spec_bhr. All are registered or derived from registers.
- Accepted predict (pred_valid && pred_ready && !(res_valid && res_mispredict)):
  - ckpt[tail] <= spec_bhr (pre-shift value).
  - spec_bhr <= {spec_bhr[BHR_DEPTH-2:0], pred_taken}.
  - tail++, count++.
  - cur_bhr reflects the shift one cycle later.
- pred_valid while !pred_ready: ignored, no state change. Fetch must stall.
- Resolve without mispredict: no state change. res_bhr is valid in the same cycle.
- Mispredict (res_valid && res_mispredict) has top priority:
  - Same-cycle pred_valid is dropped: no allocation, no shift.
  - spec_bhr <= {ckpt[res_tag][BHR_DEPTH-2:0], res_taken}.
  - tail <= res_tag+1. All younger branches are squashed.
  - count <= ((res_tag - head) mod CKPT_DEPTH) + 1, minus 1 if retire_valid in the same cycle.
- Retire (retire_valid && count!=0): head++, count--.
  - Simultaneous with an accepted predict: count unchanged, both pointers advance. This is legal even when full.
  - Retire while count==0: ignored; simulation assertion fires.
- Mispredict on head tag with retire in the same cycle: count becomes 0, head=tail=res_tag+1.
- res_tag must lie in [head, tail) modulo wrap. Violation is a simulation assertion.
- Only one resolve per cycle. Any same-cycle combination of predict, resolve and retire is legal.

Optional Feature:
- Macro: BHR_ARCH_RECOVER_EN.
- Enabled:
  - Adds input flush (1 bit) and an internal arch_bhr register, reset to 0.
  - On each retire_valid, arch_bhr shifts in the retired branch's checkpointed direction. The direction bit is stored as an extra per-slot bit at predict time and overwritten with res_taken on mispredict.
  - flush (exception/interrupt) has priority over everything: spec_bhr <= arch_bhr next cycle, head=tail=0, count=0, pred dropped.
- Disabled: no flush port, no arch_bhr. Recovery is only via mispredict.

Decomposition:
- Shared package/sys_defs:
  - BHR_T typedef (logic [BHR_DEPTH-1:0]).
  - BR_TAG typedef (logic [TAG_W-1:0]).
  - CKPT_DEPTH constant.
- Sub-module: bhr_ckpt_buf, the circular buffer with head/tail/count, one write port and one async read port. bhr_checkpoint wraps it with the spec_bhr shift and recovery logic.

Test Plan (BHR_DEPTH=4, CKPT_DEPTH=4):
- Reset, then predicts T,N,T on consecutive cycles -> cur_bhr 0001, 0010, 0101; pred_tag 0,1,2; count 3.
- Fill 4 predicts with no retire -> pred_ready=0 at count 4. 5th pred_valid ignored: cur_bhr and tail unchanged. Retire plus predict in the same cycle -> count stays 4, head=1, tail=1.
- From the first scenario, mispredict res_tag=1, res_taken=1 -> res_bhr=0001; next cycle cur_bhr=0011, tail=2, count=2.
- Same-cycle pred_valid and mispredict res_tag=0 with retire_valid -> pred dropped, count=0, head=tail=1, cur_bhr={ckpt0[2:0],res_taken}.
- Assert reset low mid-stream with count=3 -> immediately count=0, cur_bhr=0, pred_ready=1.
- BHR_ARCH_RECOVER_EN: retire T,T, then predict N, then flush -> next cycle cur_bhr=0011, count=0.
